// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory fetch/data arbiter.
package mem_arb_pkg;

    localparam int XLEN = 32;
    localparam int LS_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Which requester owns the transaction currently in flight.
    function automatic owner_e state_owner(input arb_state_e st);
        owner_e own;
        case (st)
            IF_BUSY: own = OWN_IF;
            D_BUSY:  own = OWN_D;
            default: own = OWN_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              if_req;
    logic [XLEN-1:0]   if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [XLEN-1:0]   if_rdata;

    logic              d_req;
    logic              d_we;
    logic [LS_W-1:0]   d_ls;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [XLEN-1:0]   d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [LS_W-1:0]   mem_ls;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_ls, d_addr, d_wdata,
        input  mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_ls, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_ls, d_addr, d_wdata,
        output mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_ls, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_perf.sv
// Wait-cycle counters: cycles a requester spends with req high and no grant.
module mem_arb_perf
    import mem_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic            if_gnt,
    input  logic            d_req,
    input  logic            d_gnt,
    output logic [XLEN-1:0] perf_if_wait,
    output logic [XLEN-1:0] perf_d_wait
);

    logic [XLEN-1:0] if_wait_r;
    logic [XLEN-1:0] d_wait_r;

    // Free-running wrap-around stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_wait_r <= {XLEN{1'b0}};
            d_wait_r  <= {XLEN{1'b0}};
        end else begin
            if (if_req && !if_gnt) begin
                if_wait_r <= if_wait_r + 32'd1;
            end
            if (d_req && !d_gnt) begin
                d_wait_r <= d_wait_r + 32'd1;
            end
        end
    end

    assign perf_if_wait = if_wait_r;
    assign perf_d_wait  = d_wait_r;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store ports.
// Define MEM_ARB_PERF_EN to build the perf_if_wait/perf_d_wait stall counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DSTREAK = 4
)(
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus,
    output logic [XLEN-1:0] perf_if_wait,
    output logic [XLEN-1:0] perf_d_wait
);

    localparam logic [3:0] MAX_DS = 4'(MAX_DSTREAK);

    arb_state_e      state_r;
    arb_state_e      state_s;
    logic            if_gnt_s;
    logic            d_gnt_s;
    logic [3:0]      dstreak_r;

    logic            mem_req_r;
    logic            mem_we_r;
    logic [LS_W-1:0] mem_ls_r;
    logic [XLEN-1:0] mem_addr_r;
    logic [XLEN-1:0] mem_wdata_r;

    logic            if_rvalid_r;
    logic [XLEN-1:0] if_rdata_r;
    logic            d_rvalid_r;
    logic [XLEN-1:0] d_rdata_r;

    logic            done_s;

    // Next-state and grant decode; data wins unless fetch has waited out the streak.
    always_comb begin
        state_s  = state_r;
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rst) begin
                    state_s = IDLE;
                end else if (bus.d_req && (!bus.if_req || (dstreak_r < MAX_DS))) begin
                    d_gnt_s = 1'b1;
                    state_s = D_BUSY;
                end else if (bus.if_req) begin
                    if_gnt_s = 1'b1;
                    state_s  = IF_BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (bus.mem_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign done_s = (state_r != IDLE) && bus.mem_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Consecutive data grants taken while a fetch was waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            dstreak_r <= 4'd0;
        end else if (d_gnt_s) begin
            if (!bus.if_req) begin
                dstreak_r <= 4'd0;
            end else if (dstreak_r != 4'd15) begin
                dstreak_r <= dstreak_r + 4'd1;
            end
        end else if (if_gnt_s) begin
            dstreak_r <= 4'd0;
        end
    end

    // Transaction copy toward memory; requesters may change fields after their grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_ls_r    <= {LS_W{1'b0}};
            mem_addr_r  <= {XLEN{1'b0}};
            mem_wdata_r <= {XLEN{1'b0}};
        end else if (d_gnt_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= bus.d_we;
            mem_ls_r    <= bus.d_ls;
            mem_addr_r  <= bus.d_addr;
            mem_wdata_r <= bus.d_wdata;
        end else if (if_gnt_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_ls_r    <= {LS_W{1'b0}};
            mem_addr_r  <= bus.if_addr;
            mem_wdata_r <= {XLEN{1'b0}};
        end else if (done_s) begin
            mem_req_r   <= 1'b0;
        end
    end

    // Completion pulse and read data routed back to the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid_r <= 1'b0;
            if_rdata_r  <= {XLEN{1'b0}};
            d_rvalid_r  <= 1'b0;
            d_rdata_r   <= {XLEN{1'b0}};
        end else begin
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            if (done_s) begin
                case (state_owner(state_r))
                    OWN_IF: begin
                        if_rvalid_r <= 1'b1;
                        if_rdata_r  <= bus.mem_rdata;
                    end
                    OWN_D: begin
                        d_rvalid_r <= 1'b1;
                        d_rdata_r  <= mem_we_r ? {XLEN{1'b0}} : bus.mem_rdata;
                    end
                    default: begin
                        if_rvalid_r <= 1'b0;
                        d_rvalid_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.if_gnt    = if_gnt_s;
    assign bus.d_gnt     = d_gnt_s;
    assign bus.if_rvalid = if_rvalid_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_rvalid  = d_rvalid_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_ls    = mem_ls_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clk          (clk),
        .rst          (rst),
        .if_req       (bus.if_req),
        .if_gnt       (if_gnt_s),
        .d_req        (bus.d_req),
        .d_gnt        (d_gnt_s),
        .perf_if_wait (perf_if_wait),
        .perf_d_wait  (perf_d_wait)
    );
`else
    assign perf_if_wait = {XLEN{1'b0}};
    assign perf_d_wait  = {XLEN{1'b0}};
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_DSTREAK = 4).
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] perf_if_wait;
    logic [31:0] perf_d_wait;
    int          n_cmp;
    int          n_mis;
    bit          gq[$];
    int          d_rv_cnt;
    int          if_rv_cnt;
    int          both_cnt;
    bit          exp_t3 [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_DSTREAK(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .perf_if_wait (perf_if_wait),
        .perf_d_wait  (perf_d_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Log grant order (1 = data, 0 = fetch) and rvalid pulses over ncyc cycles.
    task automatic record_grants(input int ncyc);
        gq.delete();
        d_rv_cnt  = 0;
        if_rv_cnt = 0;
        both_cnt  = 0;
        for (int i = 0; i < ncyc; i++) begin
            #1;
            if (bus.d_gnt === 1'b1) gq.push_back(1'b1);
            else if (bus.if_gnt === 1'b1) gq.push_back(1'b0);
            if (bus.d_gnt === 1'b1 && bus.if_gnt === 1'b1) both_cnt++;
            if (bus.d_rvalid === 1'b1) d_rv_cnt++;
            if (bus.if_rvalid === 1'b1) if_rv_cnt++;
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        bus.if_req = 1'b0;   bus.if_addr = 32'h0;
        bus.d_req = 1'b0;    bus.d_we = 1'b0;   bus.d_ls = 4'h0;
        bus.d_addr = 32'h0;  bus.d_wdata = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        tick();
        tick();
        chk("rst_mem_req",   bus.mem_req,   32'd0);
        chk("rst_gnts",      {bus.if_gnt, bus.d_gnt}, 32'd0);
        chk("rst_rvalids",   {bus.if_rvalid, bus.d_rvalid}, 32'd0);
        chk("rst_mem_addr",  bus.mem_addr,  32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata",     bus.if_rdata | bus.d_rdata, 32'd0);
        chk("rst_perf",      perf_if_wait | perf_d_wait, 32'd0);
        rst = 1'b0;
        tick();

        // Lone fetch, one-cycle memory.
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
        #1;
        chk("t1_if_gnt", bus.if_gnt, 32'd1);
        chk("t1_d_gnt",  bus.d_gnt,  32'd0);
        tick();
        bus.if_req = 1'b0; bus.if_addr = 32'hFFFF_FFF0;
        #1;
        chk("t1_mem_req",  bus.mem_req,  32'd1);
        chk("t1_mem_addr", bus.mem_addr, 32'h10);
        chk("t1_we_ls",    {bus.mem_we, bus.mem_ls}, 32'd0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0513;
        tick();
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        #1;
        chk("t1_if_rvalid", bus.if_rvalid, 32'd1);
        chk("t1_if_rdata",  bus.if_rdata,  32'h0000_0513);
        chk("t1_mem_req_lo", bus.mem_req,  32'd0);
        chk("t1_d_rvalid",  bus.d_rvalid,  32'd0);
        tick();
        chk("t1_if_rvalid_once", bus.if_rvalid, 32'd0);

        // mem_ready while idle is ignored.
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("idle_rdy_rvalid", {bus.if_rvalid, bus.d_rvalid}, 32'd0);
        chk("idle_rdy_req",    bus.mem_req,  32'd0);
        chk("idle_rdy_rdata",  bus.if_rdata, 32'h0000_0513);

        // Simultaneous fetch and store: data first, store returns 0.
        bus.if_req = 1'b1; bus.if_addr = 32'h14;
        bus.d_req = 1'b1;  bus.d_we = 1'b1; bus.d_ls = 4'b0010;
        bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t2_d_gnt",  bus.d_gnt,  32'd1);
        chk("t2_if_gnt", bus.if_gnt, 32'd0);
        tick();
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = 32'h0;
        #1;
        chk("t2_mem_we",    bus.mem_we,    32'd1);
        chk("t2_mem_ls",    bus.mem_ls,    32'd2);
        chk("t2_mem_addr",  bus.mem_addr,  32'h100);
        chk("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("t2_d_rvalid",  bus.d_rvalid, 32'd1);
        chk("t2_d_rdata",   bus.d_rdata,  32'd0);
        chk("t2_if_gnt2",   bus.if_gnt,   32'd1);
        tick();
        bus.if_req = 1'b0;
        #1;
        chk("t2_f_addr",  bus.mem_addr, 32'h14);
        chk("t2_f_we_ls", {bus.mem_we, bus.mem_ls}, 32'd0);
        chk("t2_f_req",   bus.mem_req,  32'd1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0013;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("t2_if_rvalid", bus.if_rvalid, 32'd1);
        chk("t2_if_rdata",  bus.if_rdata,  32'h13);

        // Starvation guard: both requests held, memory always ready.
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_ls = 4'h0; bus.d_addr = 32'h300;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
        record_grants(20);
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b0;
        chk("t3_n_grants", gq.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < gq.size()) chk($sformatf("t3_grant%0d_is_d", i), gq[i], exp_t3[i]);
        end
        chk("t3_d_rvalids",  d_rv_cnt,  32'd8);
        chk("t3_if_rvalids", if_rv_cnt, 32'd1);
        chk("t3_dual_gnt",   both_cnt,  32'd0);
        tick();
        tick();

        // Ten-cycle memory stall on a load from 0x200.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_ls = 4'b0100; bus.d_addr = 32'h200;
        #1;
        chk("t4_d_gnt", bus.d_gnt, 32'd1);
        tick();
        bus.d_req = 1'b0; bus.d_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t4_stall_req",  {bus.mem_req, bus.d_gnt, bus.if_gnt, bus.d_rvalid}, 32'b1000);
            chk("t4_stall_addr", bus.mem_addr, 32'h200);
            tick();
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("t4_d_rvalid", bus.d_rvalid, 32'd1);
        chk("t4_d_rdata",  bus.d_rdata,  32'hCAFE_F00D);
        tick();
        chk("t4_after", {bus.d_rvalid, bus.mem_req, bus.d_gnt, bus.if_gnt}, 32'd0);

        // Reset in D_BUSY after three streak grants.
        bus.if_req = 1'b1; bus.d_req = 1'b1; bus.d_addr = 32'h400;
        bus.mem_ready = 1'b1;
        record_grants(5);
        chk("t5_pre_grants", gq.size(), 32'd3);
        rst = 1'b1; bus.if_req = 1'b0; bus.d_req = 1'b0;
        tick();
        rst = 1'b0; bus.mem_ready = 1'b0;
        #1;
        chk("t5_mem_req",  bus.mem_req,  32'd0);
        chk("t5_d_rvalid", bus.d_rvalid, 32'd0);
        tick();
        chk("t5_no_rvalid", {bus.d_rvalid, bus.if_rvalid}, 32'd0);
        bus.if_req = 1'b1; bus.d_req = 1'b1; bus.mem_ready = 1'b1;
        record_grants(10);
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b0;
        chk("t5_n_grants", gq.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) chk($sformatf("t5_grant%0d_is_d", i), gq[i], exp_t3[i]);
        end
        tick();
        tick();

        // Fetch waits three cycles behind a data load.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h80;
        bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 32'h500;
        #1;
        chk("t6_d_gnt", bus.d_gnt, 32'd1);
        tick();
        bus.d_req = 1'b0;
        tick();
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("t6_if_gnt", bus.if_gnt, 32'd1);
`ifdef MEM_ARB_PERF_EN
        chk("t6_perf_if", perf_if_wait, 32'd3);
`else
        chk("t6_perf_if", perf_if_wait, 32'd0);
`endif
        chk("t6_perf_d", perf_d_wait, 32'd0);
        tick();
        bus.if_req = 1'b0;
`ifdef MEM_ARB_PERF_EN
        chk("t6_perf_if_hold", perf_if_wait, 32'd3);
`else
        chk("t6_perf_if_hold", perf_if_wait, 32'd0);
`endif
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0093;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("t6_if_rvalid", bus.if_rvalid, 32'd1);
        chk("t6_if_rdata",  bus.if_rdata,  32'h93);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port unified memory between the CPU's instruction-fetch port and its load/store data port, letting the RV32 core run from a single RAM instead of split instruction/data memories. Sits between the core (fetch and data request ports) and the memory. Grants one transaction at a time under data-priority with an anti-starvation guard, and holds the transaction until the memory reports ready. Registered read data and completion pulses are returned to the owning requester.

## Interface
- `MAX_DSTREAK`, default 4: consecutive data grants allowed while a fetch is pending before fetch is forced. Legal range 1..15.
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held high until `if_gnt`
- `if_addr`  in  32  fetch address; stable while `if_req` is high
- `if_gnt`  out  1  one-cycle grant pulse to fetch
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid
- `if_rdata`  out  32  fetched instruction
- `d_req`  in  1  data request; held until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_ls`  in  4  load/store width/sign code, passed through unchanged
- `d_addr`  in  32  data address
- `d_wdata`  in  32  store data
- `d_gnt`  out  1  one-cycle grant pulse to data
- `d_rvalid`  out  1  one-cycle completion pulse for load or store
- `d_rdata`  out  32  load data; 0 after a store
- `mem_req`  out  1  transaction active toward memory
- `mem_we`, `mem_ls`, `mem_addr`, `mem_wdata`  out  1/4/32/32  latched transaction fields
- `mem_ready`  in  1  memory completes the current transaction this cycle
- `mem_rdata`  in  32  read data, valid with `mem_ready`
- `perf_if_wait`, `perf_d_wait`  out  32  stall counters (see Configuration)

## Operation
- FSM states are IDLE, IF_BUSY and D_BUSY.
- **IDLE**, choosing a winner:
  - if `d_req` and (not `if_req` or `dstreak < MAX_DSTREAK`), grant data and go to D_BUSY;
  - else if `if_req`, grant fetch and go to IF_BUSY.
- **Grant action:** `*_gnt` is asserted combinationally in that cycle. Address, we, ls and wdata are latched into the `mem_*` registers. A fetch latches `we=0` and `ls=0`.
- **`dstreak` (4-bit):**
  - increments on each data grant while `if_req` is high, saturating at 15;
  - clears on any fetch grant;
  - clears on a data grant with `if_req` low.
- **BUSY:**
  - `mem_req` stays high and the `mem_*` fields stay stable until `mem_ready` is sampled high.
  - On ready, the FSM returns to IDLE.
  - The owner's `rvalid` pulses the next cycle. `rdata` is registered from `mem_rdata`, or forced to 0 for a store.
- A requester holds its fields only until its `gnt`. After that the arbiter owns the copy.
- Requests arriving during BUSY wait; no queuing beyond the requester's held `req`.

## Timing
- **Reset values:** state IDLE; `mem_req`, all `gnt` and all `rvalid` 0; all data/addr outputs 0; `dstreak` 0.
- **Latency:**
  - request seen in IDLE at cycle N: `gnt` at N, `mem_req` high at N+1;
  - `mem_ready` at N+k (k≥1): `rvalid` at N+k+1;
  - the next grant is possible at N+k+1, so the minimum period is 2 cycles per transaction.
- **Simultaneous `if_req` and `d_req`:** data wins unless `dstreak == MAX_DSTREAK`.
- **`mem_ready` high while IDLE:** ignored.
- **`rst` mid-transaction:**
  - the transaction is abandoned and `mem_req` is 0 the next cycle;
  - no `rvalid` is issued;
  - the memory must tolerate an abandoned request.
- **Memory stall:** unbounded `mem_ready` low keeps the FSM in BUSY; no timeout.

## Configuration
- **`MEM_ARB_PERF_EN` defined:**
  - `perf_if_wait` counts cycles with `if_req`=1 and no `if_gnt`;
  - `perf_d_wait` counts the same for data;
  - both are 32-bit, wrap on overflow and reset to 0.
- **`MEM_ARB_PERF_EN` undefined:** both outputs are tied to 0 and no counter logic is built. Ports remain present so the port list is stable.

## Structure
- **Package `mem_arb_pkg`:** state enum (IDLE/IF_BUSY/D_BUSY), `LS_W=4`, `XLEN=32`, owner encoding.
- **Sub-module `mem_arb_perf`:** the two wait counters, instantiated only under `MEM_ARB_PERF_EN`.

## Test plan
- Lone fetch, `if_addr=0x0000_0010`, memory ready after 1 cycle with `mem_rdata=0x0000_0513` → `if_gnt` at N, `mem_addr=0x10`, `if_rvalid` at N+2 with `if_rdata=0x0000_0513`.
- Simultaneous `if_req` and `d_req` (store 0xDEADBEEF to 0x100, `d_ls=4'b0010`) → `d_gnt` first with `mem_we=1` and `mem_ls=2`, `d_rvalid` with `d_rdata=0`, then `if_gnt`.
- Starvation check, `MAX_DSTREAK=4`: `d_req` and `if_req` held high continuously → exactly 4 data grants, then a fetch grant, then the streak restarts.
- Memory stall of 10 cycles on a load from 0x200 → `mem_req` and `mem_addr=0x200` stable for 10 cycles, single `d_rvalid` pulse, no extra grants.
- `rst` asserted in D_BUSY → `mem_req=0` next cycle, no `d_rvalid`, state IDLE, `dstreak=0`.
- Performance counters, with `MEM_ARB_PERF_EN`: fetch waits 3 cycles behind a data access → `perf_if_wait=3`. Without the macro → both `perf_*` read 0.
